// File: rtl/boot_loader.sv
// Purpose     : copies LENGTH bytes from program ROM into system RAM at LOAD_BASE, keeping the CPU halted and summing the bytes.
// Latency     : one settle cycle plus one write cycle per byte (2 cycles/byte with immediate ram_ack); done rises on the edge that takes the last ack.
// Backpressure: each RAM write is held (address, data, enable stable) until ram_ack; no timeout, the copy simply stalls.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   start                 - begin a copy (only honoured when idle or done)
//   rom_address/rom_data_in - registered ROM address, combinational ROM data back
//   ram_address/ram_data_out/ram_write_enable/ram_ack - RAM write request, held until acked
//   busy, done, checksum, cpu_halt - copy status, sticky done flag, 8-bit sum, CPU hold
module boot_loader #(
  parameter int          ROM_ADDR_WIDTH = 6,
  parameter int          LENGTH         = 64,
  parameter logic [15:0] LOAD_BASE      = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]                rom_data_in,
  output logic [15:0]               ram_address,
  output logic [7:0]                ram_data_out,
  output logic                      ram_write_enable,
  input  logic                      ram_ack,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                checksum,
  output logic                      cpu_halt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Index of the final byte; when LENGTH fills the whole ROM this is all-ones,
  // and the copy ends there instead of letting the counter wrap.
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX = ROM_ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] ONE      = ROM_ADDR_WIDTH'(1);

  logic [1:0]                state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] count_q, count_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
  logic [15:0]               ram_address_q, ram_address_d;
  logic [7:0]                ram_data_q, ram_data_d;
  logic                      ram_we_q, ram_we_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [7:0]                checksum_q, checksum_d;
  logic                      cpu_halt_q, cpu_halt_d;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rom_address_d = rom_address_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_we_d      = ram_we_q;
    busy_d        = busy_q;
    done_d        = done_q;
    checksum_d    = checksum_q;
    cpu_halt_d    = cpu_halt_q;

    case (state_q)
      // IDLE already has done=0 and cpu_halt=1, so sharing the restart path
      // with DONE gives both states identical start behaviour.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          count_d       = '0;
          rom_address_d = '0;
          checksum_d    = 8'h00;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          cpu_halt_d    = 1'b1;
          state_d       = ST_SETTLE;
        end
      end

      // ROM data is combinational from the address registered last edge;
      // capture it now that it has had a full cycle to settle.
      ST_SETTLE: begin
        ram_data_d    = rom_data_in;
        ram_address_d = LOAD_BASE + 16'(count_q);
        checksum_d    = checksum_q + rom_data_in;
        ram_we_d      = 1'b1;
        state_d       = ST_WRITE;
      end

      ST_WRITE: begin
        if (ram_ack) begin
          ram_we_d = 1'b0;
          if (count_q == LAST_IDX) begin
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cpu_halt_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            count_d       = count_q + ONE;
            rom_address_d = count_q + ONE;
            state_d       = ST_SETTLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rom_address_q <= '0;
      ram_address_q <= LOAD_BASE;
      ram_data_q    <= 8'h00;
      ram_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      checksum_q    <= 8'h00;
      cpu_halt_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rom_address_q <= rom_address_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_we_q      <= ram_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      checksum_q    <= checksum_d;
      cpu_halt_q    <= cpu_halt_d;
    end
  end

  assign rom_address      = rom_address_q;
  assign ram_address      = ram_address_q;
  assign ram_data_out     = ram_data_q;
  assign ram_write_enable = ram_we_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign checksum         = checksum_q;
  assign cpu_halt         = cpu_halt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Purpose     : scoreboard bench for boot_loader; three instances (64 bytes @0200, 1 byte @0040, 4 bytes @FFFE).
// Latency     : reference model advances on the rising edge, monitor compares on the falling edge.
// Backpressure: per-instance ram_ack driver: tied high, 3-cycle delay, or random.
module tb_boot_loader;

  localparam int N  = 3;
  localparam int AW = 6;

  function automatic int len_of(input int i);
    return (i == 0) ? 64 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [15:0] base_of(input int i);
    return (i == 0) ? 16'h0200 : ((i == 1) ? 16'h0040 : 16'hFFFE);
  endfunction

  // Checksums of the fixed ROM image over each instance's length.
  function automatic logic [7:0] fixed_sum(input int i);
    return (i == 0) ? 8'h55 : ((i == 1) ? 8'hA2 : 8'h08);
  endfunction

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  logic [7:0]    rom_mem [64];
  logic [AW-1:0] rom_a   [N];
  logic [7:0]    rom_d   [N];
  logic [15:0]   ram_a   [N];
  logic [7:0]    ram_d   [N];
  logic          we      [N];
  logic          ack     [N];
  logic          busy_o  [N];
  logic          done_o  [N];
  logic          halt_o  [N];
  logic [7:0]    sum_o   [N];

  genvar g;
  for (g = 0; g < N; g++) begin : g_dut
    assign rom_d[g] = rom_mem[rom_a[g]];
    boot_loader #(
      .ROM_ADDR_WIDTH(AW),
      .LENGTH        (len_of(g)),
      .LOAD_BASE     (base_of(g))
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .rom_address     (rom_a[g]),
      .rom_data_in     (rom_d[g]),
      .ram_address     (ram_a[g]),
      .ram_data_out    (ram_d[g]),
      .ram_write_enable(we[g]),
      .ram_ack         (ack[g]),
      .busy            (busy_o[g]),
      .done            (done_o[g]),
      .checksum        (sum_o[g]),
      .cpu_halt        (halt_o[g])
    );
  end

  // ---------------- stimulus-owned controls ----------------
  int ack_mode;
  bit rom_fixed;
  bit fin_req;
  int tmo_req;

  // ---------------- ram_ack driver ----------------
  int held [N];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_mode == 0) begin
        ack[i] = 1'b1;
      end else if (ack_mode == 1) begin
        if (we[i]) begin
          ack[i] = (held[i] >= 3);
          held[i]++;
        end else begin
          held[i] = 0;
          ack[i]  = 1'b0;
        end
      end else begin
        ack[i] = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // ---------------- reference model ----------------
  // Copy-level view: bytes remaining, whether a write is on the bus, index of
  // the byte in flight. Expected writes are queued as {address, data}.
  int          m_rem  [N];
  int          m_idx  [N];
  int          m_wait [N];
  bit          m_pend [N];
  bit          m_done [N];
  logic [7:0]  m_sum  [N];
  logic [15:0] m_ra   [N];
  logic [7:0]  m_rd   [N];
  logic [23:0] exp_q  [N][$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_rem[i] = 0; m_idx[i] = 0; m_wait[i] = 0; m_pend[i] = 0; m_done[i] = 0;
        m_sum[i] = 8'h00; m_ra[i] = base_of(i); m_rd[i] = 8'h00;
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_rem[i] == 0) begin
          if (start) begin
            m_rem[i] = len_of(i); m_idx[i] = 0; m_sum[i] = 8'h00;
            m_done[i] = 0; m_pend[i] = 0; m_wait[i] = 0;
          end
        end else if (!m_pend[i]) begin
          m_rd[i]  = rom_mem[m_idx[i][AW-1:0]];
          m_sum[i] = m_sum[i] + m_rd[i];
          m_ra[i]  = 16'(base_of(i) + m_idx[i]);
          exp_q[i].push_back({m_ra[i], m_rd[i]});
          m_pend[i] = 1;
        end else if (ack[i]) begin
          m_pend[i] = 0;
          m_rem[i]--;
          if (m_rem[i] == 0) m_done[i] = 1;
          else m_idx[i]++;
        end else begin
          m_wait[i]++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd  [N];
  int t0  [N];
  int nwr [N];
  bit pb  [N];
  bit pd  [N];
  int tmo_seen = 0;
  bit fin_ack = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at t=%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (tmo_req != tmo_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_timeout at t=%0t: got %0d expired waits, expected 0", $time, tmo_req - tmo_seen);
      tmo_seen = tmo_req;
    end
    for (int i = 0; i < N; i++) begin
      chk("busy",        i, 32'(busy_o[i]), 32'(m_rem[i] != 0));
      chk("done",        i, 32'(done_o[i]), 32'(m_done[i]));
      chk("cpu_halt",    i, 32'(halt_o[i]), 32'(!m_done[i]));
      chk("checksum",    i, 32'(sum_o[i]),  32'(m_sum[i]));
      chk("rom_address", i, 32'(rom_a[i]),  32'(m_idx[i][AW-1:0]));
      chk("ram_we",      i, 32'(we[i]),     32'(m_pend[i]));
      chk("ram_address", i, 32'(ram_a[i]),  32'(m_ra[i]));
      chk("ram_data",    i, 32'(ram_d[i]),  32'(m_rd[i]));
      if (!reset) begin
        rd[i]  = 0;
        nwr[i] = 0;
      end else begin
        if (busy_o[i] && !pb[i]) begin
          t0[i]  = cyc;
          nwr[i] = 0;
        end
        if (we[i]) begin
          if (rd[i] >= exp_q[i].size()) begin
            chk("write_queue_depth", i, 32'(exp_q[i].size()), 32'(rd[i] + 1));
          end else begin
            chk("write_addr", i, 32'(ram_a[i]), 32'(exp_q[i][rd[i]][23:8]));
            chk("write_data", i, 32'(ram_d[i]), 32'(exp_q[i][rd[i]][7:0]));
            if (ack[i]) begin
              rd[i]++;
              nwr[i]++;
            end
          end
        end
        if (done_o[i] && !pd[i]) begin
          chk("copy_cycles", i, 32'(cyc - t0[i]), 32'(2 * len_of(i) + m_wait[i]));
          chk("write_count", i, 32'(nwr[i]), 32'(len_of(i)));
          if (rom_fixed) chk("fixed_checksum", i, 32'(sum_o[i]), 32'(fixed_sum(i)));
        end
      end
      pb[i] = busy_o[i];
      pd[i] = done_o[i];
    end
    if (fin_req && !fin_ack) begin
      for (int i = 0; i < N; i++) chk("unconsumed_writes", i, 32'(exp_q[i].size()), 32'(rd[i]));
      fin_ack = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_all_done(input int limit);
    int n;
    n = 0;
    while (!(done_o[0] && done_o[1] && done_o[2]) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) tmo_req++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [7:0] img [10];
    int n;
    img = '{8'ha2, 8'he0, 8'h86, 8'h00, 8'ha5, 8'h00, 8'h38, 8'h08, 8'h68, 8'h00};
    ack_mode  = 0;
    rom_fixed = 1;
    fin_req   = 0;
    tmo_req   = 0;
    start     = 1'b0;
    reset     = 1'b0;
    for (int k = 0; k < 64; k++) rom_mem[k] = (k < 10) ? img[k] : 8'h00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Immediate ack: 2 cycles per byte.
    pulse_start();
    wait_all_done(400);

    // Ack delayed 3 cycles on every write: 5 cycles per byte.
    ack_mode = 1;
    pulse_start();
    wait_all_done(800);

    // Reset in the middle of byte 5's write, then a fresh copy.
    pulse_start();
    n = 0;
    while (!(rom_a[0] == 6'd5 && we[0]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) tmo_req++;
    #1 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    pulse_start();
    wait_all_done(800);

    // Start held high: restarts happen only from DONE.
    ack_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    repeat (300) @(posedge clk);
    #1 start = 1'b0;
    wait_all_done(400);

    // Random ROM image, random ack, random start pulses (mostly ignored while busy).
    rom_fixed = 0;
    ack_mode  = 2;
    do_reset();
    for (int k = 0; k < 64; k++) rom_mem[k] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 5)) @(posedge clk);
      pulse_start();
      wait_all_done(1000);
    end
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1 start = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1 start = 1'b0;
    wait_all_done(1000);

    fin_req = 1;
    n = 0;
    while (!fin_ack && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
